// File: rtl/dsched_pkg.sv
// Shared types and helpers for the display page scheduler.
package dsched_pkg;

  typedef enum logic {
    AUTO   = 1'b0,
    MANUAL = 1'b1
  } dsched_state_e;

  localparam logic [31:0] SEG_BLANK = 32'h0;

  // Page index width; a two-source scheduler still needs one bit.
  function automatic int calc_pw(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Button conditioner: 2-flop synchronizer, stability counter, rising-edge press pulse.
module btn_debounce #(
  parameter int DEB_CYC = 2_000_000
) (
  input  logic clk,
  input  logic rstn,
  input  logic raw,
  output logic press
);

  localparam int CW = (DEB_CYC > 1) ? $clog2(DEB_CYC) : 1;

  logic [1:0]    sync;
  logic [CW-1:0] cnt;
  logic          level;

  // The level flips only after the synced input has disagreed with it for
  // DEB_CYC consecutive cycles; any agreement in between restarts the count.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync  <= 2'b00;
      cnt   <= '0;
      level <= 1'b0;
      press <= 1'b0;
    end else begin
      sync  <= {sync[0], raw};
      press <= 1'b0;
      if (sync[1] == level) begin
        cnt <= '0;
      end else if (cnt == CW'(DEB_CYC - 1)) begin
        cnt   <= '0;
        level <= sync[1];
        press <= sync[1];
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/disp_page_sched.sv
// Time-shares the seven-segment word among N_SRC sources, one page at a time.
// Optional DSCHED_HOLD_EN adds a hold input that freezes the display and dwell timer.
module disp_page_sched
  import dsched_pkg::*;
#(
  parameter  int N_SRC     = 4,
  parameter  int DWELL_CYC = 100_000_000,
  parameter  int DEB_CYC   = 2_000_000,
  localparam int PW        = calc_pw(N_SRC)
) (
  input  logic                 clk,
  input  logic                 rstn,
`ifdef DSCHED_HOLD_EN
  input  logic                 hold,
`endif
  input  logic [32*N_SRC-1:0]  src_data,
  input  logic [N_SRC-1:0]     src_valid,
  input  logic                 btn_next,
  input  logic                 btn_mode,
  output logic [31:0]          seg_data,
  output logic [PW-1:0]        page,
  output logic                 auto_mode,
  output logic                 page_change
);

  localparam int DW = $clog2(DWELL_CYC);

  typedef struct packed {
    logic          found;
    logic [PW-1:0] idx;
  } sel_t;

  dsched_state_e              state;
  logic [DW-1:0]              dwell;
  logic [N_SRC-1:0][31:0]     words;
  logic                       next_evt, mode_evt;
  logic                       frz, forced, dwell_hit, step_req, adv;
  sel_t                       nxt;

  assign words = src_data;

`ifdef DSCHED_HOLD_EN
  assign frz = hold;
`else
  assign frz = 1'b0;
`endif

  btn_debounce #(.DEB_CYC(DEB_CYC)) u_deb_next (
    .clk   (clk),
    .rstn  (rstn),
    .raw   (btn_next),
    .press (next_evt)
  );

  btn_debounce #(.DEB_CYC(DEB_CYC)) u_deb_mode (
    .clk   (clk),
    .rstn  (rstn),
    .raw   (btn_mode),
    .press (mode_evt)
  );

  // First valid index after cur, wrapping; the loop runs backwards so the
  // nearest candidate is the last one written.
  function automatic sel_t next_valid(input logic [PW-1:0] cur,
                                      input logic [N_SRC-1:0] vld);
    sel_t r;
    int   idx;
    r.found = 1'b0;
    r.idx   = cur;
    for (int k = N_SRC - 1; k >= 1; k--) begin
      idx = (int'(cur) + k) % N_SRC;
      if (vld[idx[PW-1:0]]) begin
        r.found = 1'b1;
        r.idx   = idx[PW-1:0];
      end
    end
    return r;
  endfunction

  assign nxt       = next_valid(page, src_valid);
  assign forced    = !src_valid[page];
  assign dwell_hit = (state == AUTO) && !frz && (dwell == DW'(DWELL_CYC - 1));
  // A mode press in the same cycle swallows a next press.
  assign step_req  = (state == MANUAL) && next_evt && !mode_evt && !frz;
  // All triggers share one target, so the page moves at most once per cycle.
  assign adv       = (forced || dwell_hit || step_req) && nxt.found;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state       <= AUTO;
      auto_mode   <= 1'b1;
      page        <= '0;
      page_change <= 1'b0;
      dwell       <= '0;
      seg_data    <= SEG_BLANK;
    end else begin
      page_change <= adv;
      if (adv) page <= nxt.idx;

      if (!frz) seg_data <= src_valid[page] ? words[page] : SEG_BLANK;

      if (mode_evt) begin
        if (state == AUTO) begin
          state     <= MANUAL;
          auto_mode <= 1'b0;
        end else begin
          state     <= AUTO;
          auto_mode <= 1'b1;
        end
      end

      // Cleared on mode changes (entering AUTO starts a fresh dwell), held at 0
      // in MANUAL, restarted on every page move or expiry.
      if (mode_evt || state == MANUAL || adv || dwell_hit) dwell <= '0;
      else if (!frz)                                      dwell <= dwell + 1'b1;
    end
  end

endmodule

// File: tb/tb_disp_page_sched.sv
// Directed bench for disp_page_sched (N_SRC=4, DWELL_CYC=10, DEB_CYC=4).
module tb_disp_page_sched;

  logic        clk, rstn;
  logic [127:0] src_data;
  logic [3:0]  src_valid;
  logic        btn_next, btn_mode;
  logic [31:0] seg_data;
  logic [1:0]  page;
  logic        auto_mode, page_change;
`ifdef DSCHED_HOLD_EN
  logic        hold;
`endif

  int checks = 0;
  int failures = 0;
  int pc_cnt = 0;
  int snap;

  localparam logic [31:0] D0 = 32'h1111_0000;
  localparam logic [31:0] D1 = 32'h2222_0001;
  localparam logic [31:0] D2 = 32'h3333_0002;
  localparam logic [31:0] D3 = 32'h4444_0003;

  disp_page_sched #(.N_SRC(4), .DWELL_CYC(10), .DEB_CYC(4)) dut (
    .clk         (clk),
    .rstn        (rstn),
`ifdef DSCHED_HOLD_EN
    .hold        (hold),
`endif
    .src_data    (src_data),
    .src_valid   (src_valid),
    .btn_next    (btn_next),
    .btn_mode    (btn_mode),
    .seg_data    (seg_data),
    .page        (page),
    .auto_mode   (auto_mode),
    .page_change (page_change)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    if (page_change === 1'b1) pc_cnt++;
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    rstn = 1'b0; btn_next = 1'b0; btn_mode = 1'b0;
    src_data = {D3, D2, D1, D0}; src_valid = 4'b1111;
`ifdef DSCHED_HOLD_EN
    hold = 1'b0;
`endif
    step(2);
    chk("rst_page", 32'(page), 0);
    chk("rst_seg", seg_data, 0);
    chk("rst_auto", 32'(auto_mode), 1);
    chk("rst_pc", 32'(page_change), 0);
    rstn = 1'b1;

    // AUTO rotation, 10-cycle dwell
    step(9);  chk("dw_p0_hold", 32'(page), 0);
    step(1);  chk("dw_p1", 32'(page), 1); chk("dw_pc1", 32'(page_change), 1);
    step(1);  chk("dw_seg1", seg_data, D1); chk("dw_pc1_off", 32'(page_change), 0);
    step(8);  chk("dw_p1_hold", 32'(page), 1);
    step(1);  chk("dw_p2", 32'(page), 2);
    step(1);  chk("dw_seg2", seg_data, D2);
    step(8);
    step(1);  chk("dw_p3", 32'(page), 3);
    step(1);  chk("dw_seg3", seg_data, D3);
    step(8);
    step(1);  chk("dw_wrap", 32'(page), 0); chk("dw_pc_wrap", 32'(page_change), 1);
    step(1);  chk("dw_seg0", seg_data, D0);

    // Sparse valid: current page 0 drops out -> forced to 1, then 3,1,...
    src_valid = 4'b1010;
    step(1);  chk("sp_forced1", 32'(page), 1); chk("sp_pc", 32'(page_change), 1);
    step(9);  chk("sp_hold1", 32'(page), 1);
    step(1);  chk("sp_p3", 32'(page), 3);
    step(9);  chk("sp_hold3", 32'(page), 3);
    step(1);  chk("sp_back1", 32'(page), 1);

    // Mode press: effect 2+4+1 cycles after the raw edge
    btn_mode = 1'b1;
    step(6);  chk("md_early", 32'(auto_mode), 1);
    btn_mode = 1'b0;
    step(1);  chk("md_manual", 32'(auto_mode), 0);
    snap = pc_cnt;
    step(10); chk("md_no_rot", 32'(page), 1); chk("md_no_pc", 32'(pc_cnt - snap), 0);

    // Bouncy next press: single advance after 4 stable cycles
    snap = pc_cnt;
    btn_next = 1'b1; step(1);
    btn_next = 1'b0; step(1);
    btn_next = 1'b1; step(1);
    btn_next = 1'b0; step(1);
    btn_next = 1'b1;
    step(6);  chk("bn_early", 32'(page), 1);
    step(1);  chk("bn_adv", 32'(page), 3); chk("bn_pc", 32'(page_change), 1);
    btn_next = 1'b0;
    step(10); chk("bn_single", 32'(pc_cnt - snap), 1); chk("bn_stay", 32'(page), 3);

    // Forced advance coincident with a next event: one step only
    src_valid = 4'b0100;
    step(1);  chk("fa_to2", 32'(page), 2);
    src_valid = 4'b1111;
    snap = pc_cnt;
    btn_next = 1'b1;
    step(6);  chk("fa_pre", 32'(page), 2);
    src_valid = 4'b1011;
    step(1);  chk("fa_page", 32'(page), 3); chk("fa_pulse", 32'(page_change), 1);
    btn_next = 1'b0;
    step(10); chk("fa_once", 32'(pc_cnt - snap), 1); chk("fa_stay", 32'(page), 3);

    // No valid source
    src_valid = 4'b0000;
    step(2);  chk("nv_page", 32'(page), 3); chk("nv_seg", seg_data, 0);
    snap = pc_cnt;
    step(5);  chk("nv_nopc", 32'(pc_cnt - snap), 0); chk("nv_page2", 32'(page), 3);
    src_valid = 4'b0100;
    step(1);  chk("nv_to2", 32'(page), 2); chk("nv_pc", 32'(page_change), 1);
    step(1);  chk("nv_seg2", seg_data, D2);

    // Back to AUTO: dwell restarts from 0
    src_valid = 4'b1111;
    btn_mode = 1'b1;
    step(6);
    btn_mode = 1'b0;
    step(1);  chk("au_back", 32'(auto_mode), 1);
    step(9);  chk("au_hold2", 32'(page), 2);
    step(1);  chk("au_p3", 32'(page), 3);
    step(3);  chk("au_seg3", seg_data, D3);

`ifdef DSCHED_HOLD_EN
    // Hold with dwell at 3: nothing moves for 30 cycles, then 6 more to expiry
    hold = 1'b1;
    snap = pc_cnt;
    step(30);
    chk("hd_page", 32'(page), 3); chk("hd_seg", seg_data, D3);
    chk("hd_nopc", 32'(pc_cnt - snap), 0);
    hold = 1'b0;
    step(6);  chk("hd_resume_hold", 32'(page), 3);
    step(1);  chk("hd_resume_adv", 32'(page), 0);
    step(1);  chk("hd_seg0", seg_data, D0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
